// File: rtl/color_pipe_pkg.sv
// Types and constants shared by the stages of the chromatic-adaptation color pipe.
// A tagged pixel carries frame-geometry markers alongside the 24-bit RGB value.
package color_pipe_pkg;

  localparam int CHAN_W   = 8;
  localparam int PIXEL_W  = 3 * CHAN_W;
  localparam int TAG_W    = 3;
  localparam int TAGGED_W = PIXEL_W + TAG_W;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
    rgb_t rgb;
  } tagged_pixel_t;

  function automatic tagged_pixel_t make_tagged(input logic sof, input logic eol,
                                                input logic eof, input rgb_t rgb);
    tagged_pixel_t t;
    t.sof = sof;
    t.eol = eol;
    t.eof = eof;
    t.rgb = rgb;
    return t;
  endfunction

endpackage

// File: rtl/pixel_output_buffer_if.sv
// Pixel stream bus: push-only input from the processor, valid/ready output to the writer.
// slave is the buffer's view, master is the view of the surrounding producer/consumer.
interface pixel_output_buffer_if;

  color_pipe_pkg::rgb_t in_rgb;
  logic                 in_valid;
  logic                 frame_start;
  color_pipe_pkg::rgb_t out_rgb;
  logic                 out_sof;
  logic                 out_eol;
  logic                 out_eof;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_rgb, in_valid, frame_start, out_ready,
    input  out_rgb, out_sof, out_eol, out_eof, out_valid
  );

  modport slave (
    input  in_rgb, in_valid, frame_start, out_ready,
    output out_rgb, out_sof, out_eol, out_eof, out_valid
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is always on rd_data_o.
// Requests are qualified internally, so a write at full is taken only alongside a read.
module sync_fifo_fwft #(
  parameter  int WIDTH = 27,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  output logic [LVL_W-1:0] level_nxt_o
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_wr;
  logic             do_rd;

  assign full_o      = (level_q == LVL_DEPTH);
  assign empty_o     = (level_q == {LVL_W{1'b0}});
  assign level_o     = level_q;
  assign level_nxt_o = level_d;
  assign rd_data_o   = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers and occupancy.
  always_comb begin
    do_rd    = rd_en_i && !empty_o;
    do_wr    = wr_en_i && (!full_o || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/pixel_output_buffer.sv
// Captures corrected pixels, tags them with frame geometry and queues them for the writer.
// Geometry counters advance on every input pulse, dropped or not, to keep frame alignment.
module pixel_output_buffer
  import color_pipe_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  parameter  int AF_LEVEL   = DEPTH - 4,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_output_buffer_if.slave bus,
  output logic [LVL_W-1:0]     level,
  output logic                 almost_full,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam int X_W = $clog2(IMG_WIDTH);
  localparam int Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [X_W-1:0]   X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST = Y_W'(IMG_HEIGHT - 1);
  localparam logic [X_W-1:0]   X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0]   Y_ONE  = Y_W'(1);
  localparam logic [LVL_W-1:0] AF_THR = LVL_W'(AF_LEVEL);

  logic [X_W-1:0]      x_q, x_d, x_cur;
  logic [Y_W-1:0]      y_q, y_d, y_cur;
  logic                overflow_q, overflow_d;
  logic                almost_full_q, almost_full_d;
  logic                rd_fire;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LVL_W-1:0]    fifo_level;
  logic [LVL_W-1:0]    fifo_level_nxt;
  logic [TAGGED_W-1:0] fifo_rd_data;
  tagged_pixel_t       wr_entry;
  tagged_pixel_t       head;

  // frame_start overrides the counters for the pixel arriving in the same cycle.
  always_comb begin
    x_cur = bus.frame_start ? {X_W{1'b0}} : x_q;
    y_cur = bus.frame_start ? {Y_W{1'b0}} : y_q;
    x_d   = x_cur;
    y_d   = y_cur;
    if (bus.in_valid) begin
      if (x_cur == X_LAST) begin
        x_d = {X_W{1'b0}};
        if (y_cur == Y_LAST) begin
          y_d = {Y_W{1'b0}};
        end else begin
          y_d = y_cur + Y_ONE;
        end
      end else begin
        x_d = x_cur + X_ONE;
        y_d = y_cur;
      end
    end else begin
      x_d = x_cur;
      y_d = y_cur;
    end
  end

  assign wr_entry = make_tagged((x_cur == {X_W{1'b0}}) && (y_cur == {Y_W{1'b0}}),
                                (x_cur == X_LAST),
                                (x_cur == X_LAST) && (y_cur == Y_LAST),
                                bus.in_rgb);

  assign rd_fire = !fifo_empty && bus.out_ready;
  assign drop    = bus.in_valid && fifo_full && !rd_fire;

  // A drop in the same cycle wins over the clear request.
  always_comb begin
    overflow_d    = overflow_q;
    almost_full_d = (fifo_level_nxt >= AF_THR);
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Geometry counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= {X_W{1'b0}};
      y_q           <= {Y_W{1'b0}};
      overflow_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      overflow_q    <= overflow_d;
      almost_full_q <= almost_full_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (TAGGED_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (bus.in_valid),
    .wr_data_i   (wr_entry),
    .rd_en_i     (bus.out_ready),
    .rd_data_o   (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level),
    .level_nxt_o (fifo_level_nxt)
  );

  assign head          = tagged_pixel_t'(fifo_rd_data);
  assign bus.out_rgb   = head.rgb;
  assign bus.out_sof   = head.sof;
  assign bus.out_eol   = head.eol;
  assign bus.out_eof   = head.eof;
  assign bus.out_valid = !fifo_empty;
  assign level         = fifo_level;
  assign almost_full   = almost_full_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_pixel_output_buffer.sv
// Self-checking bench for pixel_output_buffer: directed scenarios plus random traffic
// compared against a queue-based model using a linear pixel index for geometry.
module tb_pixel_output_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int AF    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] level;
  logic       almost_full;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [26:0] mq[$];
  int          pix_idx = 0;
  bit          m_ovf = 1'b0;

  pixel_output_buffer_if bus();

  pixel_output_buffer #(
    .DEPTH      (DEPTH),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .AF_LEVEL   (AF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .level          (level),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
  task automatic cycle(input bit v, input logic [23:0] rgb, input bit fs, input bit rdy, input bit clr);
    int          eff;
    bit          rd;
    bit          acc;
    logic [26:0] ent;
    @(negedge clk);
    bus.in_valid    = v;
    bus.in_rgb      = rgb;
    bus.frame_start = fs;
    bus.out_ready   = rdy;
    clear_overflow  = clr;
    eff = fs ? 0 : pix_idx;
    ent = {(eff == 0), (eff % W == W - 1), (eff == W * H - 1), rgb};
    rd  = (mq.size() > 0) && rdy;
    acc = v && ((mq.size() < DEPTH) || rd);
    @(posedge clk);
    if (rd) void'(mq.pop_front());
    if (acc) mq.push_back(ent);
    if (v && !acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    pix_idx = v ? (eff + 1) % (W * H) : eff;
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_rgb = 24'h0; bus.frame_start = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, level, almost_full, overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b level=%0d af=%b ovf=%b, required all 0",
               bus.out_valid, level, almost_full, overflow);
    end
    n_checks++;
    if ({bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb} !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_data: tags=%b%b%b rgb=%h, required 0",
               bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb);
    end
  endtask

  task automatic test_tag_sequence();
    logic [26:0] got[$];
    logic [26:0] exp;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 24'(k), 1'b0, 1'b1, 1'b0);
      if (bus.out_valid) got.push_back({bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb});
    end
    cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL tag_count: got %0d outputs, required 8", got.size());
    end
    for (int k = 1; k <= 8 && k <= got.size(); k++) begin
      exp = {(k == 1), (k % 4 == 0), (k == 8), 24'(k)};
      n_checks++;
      if (got[k-1] !== exp) begin
        n_fail++;
        $display("FAIL tag_seq[%0d]: got %h, required %h", k, got[k-1], exp);
      end
    end
    n_checks++;
    if (overflow !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tag_end: ovf=%b valid=%b, required 0 0", overflow, bus.out_valid);
    end
  endtask

  task automatic test_fill_drop();
    int exp_lvl;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1, 24'h000100 + 24'(k), 1'b0, 1'b0, 1'b0);
      exp_lvl = (k < DEPTH) ? k : DEPTH;
      n_checks++;
      if (level !== 3'(exp_lvl) || almost_full !== (exp_lvl >= AF) || overflow !== (k > DEPTH)) begin
        n_fail++;
        $display("FAIL fill[%0d]: level=%0d af=%b ovf=%b, required %0d %b %b",
                 k, level, almost_full, overflow, exp_lvl, exp_lvl >= AF, k > DEPTH);
      end
    end
    for (int j = 1; j <= DEPTH; j++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_rgb !== 24'h000100 + 24'(j)) begin
        n_fail++;
        $display("FAIL drain[%0d]: valid=%b rgb=%h, required 1 %h",
                 j, bus.out_valid, bus.out_rgb, 24'h000100 + 24'(j));
      end
      cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_end: valid=%b level=%0d, required 0 0", bus.out_valid, level);
    end
  endtask

  task automatic test_write_full_read();
    cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= DEPTH; k++) cycle(1'b1, 24'h000200 + 24'(k), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h000205, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || bus.out_rgb !== 24'h000202) begin
      n_fail++;
      $display("FAIL full_rw: level=%0d ovf=%b head=%h, required 4 0 000202",
               level, overflow, bus.out_rgb);
    end
    for (int j = 0; j < 10 && mq.size() > 0; j++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb} !== mq[0]) begin
        n_fail++;
        $display("FAIL full_rw_drain[%0d]: got %h, required %h", j,
                 {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb}, mq[0]);
      end
      cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_midline_frame_start();
    bit fs;
    for (int k = 1; k <= 6; k++) begin
      fs = (k == 1) || (k == 3);
      cycle(1'b1, 24'h000300 + 24'(k), fs, 1'b1, 1'b0);
      n_checks++;
      if (bus.out_rgb !== 24'h000300 + 24'(k) || bus.out_sof !== fs || bus.out_eol !== (k == 6)) begin
        n_fail++;
        $display("FAIL midline_fs[%0d]: rgb=%h sof=%b eol=%b, required %h %b %b", k,
                 bus.out_rgb, bus.out_sof, bus.out_eol, 24'h000300 + 24'(k), fs, k == 6);
      end
    end
    cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow_race();
    for (int k = 1; k <= DEPTH; k++) cycle(1'b1, 24'h000400 + 24'(k), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 24'h000405, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_race_drop: ovf=%b, required 1", overflow);
    end
    cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_race_clear: ovf=%b, required 0", overflow);
    end
    for (int j = 0; j < DEPTH; j++) cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midstream();
    for (int k = 1; k <= 3; k++) cycle(1'b1, 24'h000500 + 24'(k), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b level=%0d ovf=%b af=%b, required 0 0 0 0",
               bus.out_valid, level, overflow, almost_full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    pix_idx = 0;
    m_ovf = 1'b0;
    cycle(1'b1, 24'h0005AA, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sof !== 1'b1 || bus.out_rgb !== 24'h0005AA) begin
      n_fail++;
      $display("FAIL reset_first_sof: valid=%b sof=%b rgb=%h, required 1 1 0005aa",
               bus.out_valid, bus.out_sof, bus.out_rgb);
    end
    cycle(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit v, rdy, fs, clr;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom % 4) != 0;
      rdy = (i % 100 < 40) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
      fs  = ($urandom % 40) == 0;
      clr = ($urandom % 12) == 0;
      cycle(v, 24'($urandom), fs, rdy, clr);
      n_checks++;
      if (bus.out_valid !== (mq.size() > 0) || level !== 3'(mq.size()) ||
          almost_full !== (mq.size() >= AF) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: valid=%b level=%0d af=%b ovf=%b, required %b %0d %b %b",
                 i, bus.out_valid, level, almost_full, overflow,
                 mq.size() > 0, mq.size(), mq.size() >= AF, m_ovf);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if ({bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb} !== mq[0]) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: got %h, required %h", i,
                   {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_rgb}, mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_tag_sequence();
    test_fill_drop();
    test_write_full_read();
    test_midline_frame_start();
    test_overflow_race();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
